ycbcr_centroid: RTL and testbench
=================================

# ycbcr_centroid

Skin-colour segmentation and centroid tracker placed directly downstream of the RGB→YCbCr converter. It consumes the converted video stream and sync signals, and binarises each pixel against a Cb/Cr window. Per frame it accumulates the coordinates of foreground pixels, then computes the centroid with a sequential divider during vertical blanking. It emits a black/white mask image with a red crosshair at the last valid centroid, for the HDMI output path.

## Interface
- IMG_W, 1280: active pixels per line
- IMG_H, 720: active lines per frame
- CB_MIN, 77: lower Cb bound, inclusive
- CB_MAX, 127: upper Cb bound, inclusive
- CR_MIN, 133: lower Cr bound, inclusive
- CR_MAX, 173: upper Cr bound, inclusive
- clk  in  1  pixel clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- hsync_in  in  1  horizontal sync, aligned with pixel_in
- vsync_in  in  1  vertical sync, active-high
- de_in  in  1  data enable; high on active pixels
- pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned 8-bit fields
- hsync_out  out  1  hsync_in delayed by 2 cycles
- vsync_out  out  1  vsync_in delayed by 2 cycles
- de_out  out  1  de_in delayed by 2 cycles
- pixel_out  out  24  RGB output: mask value or crosshair colour
- centroid_x  out  11  centroid column, 0..IMG_W-1
- centroid_y  out  10  centroid row, 0..IMG_H-1
- centroid_valid  out  1  high while centroid_x/centroid_y hold a result from a non-empty frame

## Operation
**Mask**
- fg = (CB_MIN ≤ Cb ≤ CB_MAX) && (CR_MIN ≤ Cr ≤ CR_MAX). Y is ignored.

**Position counters**
- x: increments on each de_in=1 cycle; cleared on the cycle after the de_in falling edge.
- y: increments on each de_in falling edge; cleared on the vsync_in rising edge.
- Both saturate at IMG_W-1 and IMG_H-1 respectively; they never wrap.

**Accumulators** (updated on cycles where de_in && fg)
- sum_x (32 bit) += x.
- sum_y (32 bit) += y.
- cnt (20 bit) += 1.

**Frame end** (vsync_in rising edge)
- Copy sum_x, sum_y and cnt into the divider operands.
- Clear the accumulators.
- If de_in=1 on that same cycle, that pixel is accumulated into the cleared (new-frame) accumulators.

**Divider FSM**, states IDLE → DIV → DONE → IDLE
- IDLE → DIV on frame end when the latched cnt ≠ 0.
- On frame end with cnt = 0: stay in IDLE, clear centroid_valid, keep the old centroid values.
- DIV runs 32 cycles: two parallel restoring divisions, sum_x/cnt and sum_y/cnt, one quotient bit per cycle.
- DONE lasts one cycle: load centroid_x and centroid_y from the low bits of the quotients, set centroid_valid, return to IDLE.
- A frame end while in DIV aborts the current division and restarts with the new operands (same cnt = 0 rule applies).

**Output pixel**
- With centroid_valid=1, pixel_out = 24'hFF0000 when the stage-1 pixel has x == centroid_x or y == centroid_y.
- Otherwise pixel_out = fg ? 24'hFFFFFF : 24'h000000.
- When the delayed de is 0, pixel_out = 0.

## Timing
- Stage 1 registers fg, x, y and the sync signals. Stage 2 registers the overlay mux. Pixel and sync latency is therefore exactly 2 cycles.
- Centroid update: centroid outputs change 34 cycles after the vsync_in rising edge (1 latch cycle + 32 DIV + 1 DONE). The new values apply to the next frame's overlay.
- Centroid outputs are stable between updates. They may change mid-frame only if vertical blanking is shorter than 34 cycles; this is not a supported configuration.
- Reset (rst_n=0 sampled on clk):
  - all outputs 0, centroid_valid 0;
  - counters, accumulators and the sync delay registers cleared;
  - FSM to IDLE.
- Reset asserted mid-division discards that division.
- Arithmetic: all unsigned. sum_x fits, since 1280·720·1279 < 2^31. The quotients are always < IMG_W and < IMG_H, so truncation to 11/10 bits is lossless.

## Structure
- Shared package ycbcr_pkg holds:
  - the default threshold constants;
  - X_W=11, Y_W=10, SUM_W=32, CNT_W=20;
  - the divider state enum.
- Sync delay uses the existing delayline (N=3, DELAY=2).
- One natural sub-module, seq_divider (SUM_W/CNT_W restoring divider with start/busy/done), instantiated twice.

## Test plan
- **Single pixel:** reset, then a 16×8 test frame (IMG_W=16, IMG_H=8) with one pixel Cb=100, Cr=150 at (5,3) -> after vsync, centroid_x=5, centroid_y=3, centroid_valid=1 exactly 34 cycles after the vsync rise.
- **Block average:** foreground 2×2 block at (4..5, 2..3) -> sums 18/10, cnt 4 -> centroid (4,2), truncated.
- **Empty frame:** all pixels Cb=128 -> pixel_out=0 on every active pixel, and centroid_valid drops to 0 at frame end with the previous centroid retained.
- **Overlay:** with centroid (5,3) valid, the next frame shows pixel_out=FF0000 on column 5 and row 3, and mask values elsewhere, 2 cycles after the input.
- **Threshold edges:** Cb=77/127 and Cr=133/173 -> white; Cb=76/128 and Cr=132/174 -> black.
- **Abort and reset:** a vsync pulse re-issued 10 cycles after frame end -> the result reflects the second frame's operands. rst_n pulsed low mid-DIV -> all outputs 0, no DONE.

Source files
------------

// File: rtl/ycbcr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr_pkg
// Description : Shared constants, widths and divider FSM encoding for the
//               skin-colour segmentation / centroid tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package ycbcr_pkg;

  // Datapath widths
  localparam int X_W   = 11;   // column coordinate
  localparam int Y_W   = 10;   // row coordinate
  localparam int SUM_W = 32;   // coordinate sums
  localparam int CNT_W = 20;   // foreground pixel count

  // Default frame geometry
  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;

  // Default skin-tone window in the Cb/Cr plane (inclusive bounds)
  localparam int CB_MIN_DEF = 77;
  localparam int CB_MAX_DEF = 127;
  localparam int CR_MIN_DEF = 133;
  localparam int CR_MAX_DEF = 173;

  // Centroid divider controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Inclusive range test on an 8-bit chroma sample
  function automatic logic in_window(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/delayline.sv
`default_nettype none
// ============================================================================
// Module      : delayline
// Description : N-bit wide, DELAY-deep register delay line with synchronous
//               active-low clear.
// Ports       : clk   - clock
//               rst_n - synchronous active-low reset
//               din   - N-bit input
//               dout  - din delayed by DELAY cycles
// Revision    : 1.0 - initial release
// ============================================================================
module delayline #(
  parameter int N     = 1,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [DELAY-1:0][N-1:0] taps;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DELAY; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               DVD_W iterations follow the start cycle. Only the low Q_W
//               quotient bits are exported.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset (discards any
//                          division in progress)
//               start    - load operands and (re)start; overrides busy
//               dividend - DVD_W-bit numerator, sampled on start
//               divisor  - DVS_W-bit denominator, sampled on start (non-zero)
//               busy     - iterations in progress
//               done     - high during the final iteration; quotient is
//                          final from the following cycle
//               quotient - low Q_W bits of dividend / divisor
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import ycbcr_pkg::*;
#(
  parameter int DVD_W = SUM_W,
  parameter int DVS_W = CNT_W,
  parameter int Q_W   = X_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int             CW   = $clog2(DVD_W);
  localparam logic [CW-1:0]  LAST = CW'(DVD_W - 1);

  logic [DVD_W-1:0] quo;      // shifts dividend out, quotient bits in
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CW-1:0]    step_cnt;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic             ge;

  // Remainder is always < divisor, so the shifted trial fits in DVS_W+1 bits
  // and, when the subtraction is skipped, in DVS_W bits.
  assign trial = {rem, quo[DVD_W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = (trial >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      quo      <= dividend;
      rem      <= '0;
      dvs      <= divisor;
      step_cnt <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      rem      <= ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
      quo      <= {quo[DVD_W-2:0], ge};
      step_cnt <= step_cnt + CW'(1);
      if (step_cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (step_cnt == LAST);
  assign quotient = quo[Q_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ycbcr_centroid.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr_centroid
// Description : Binarises a YCbCr stream against a Cb/Cr window, accumulates
//               foreground coordinates per frame, divides during vertical
//               blanking and outputs the mask with a red crosshair at the
//               last valid centroid. Pixel/sync latency is 2 cycles.
// Ports       : clk, rst_n                       - clock, sync active-low reset
//               hsync_in, vsync_in, de_in         - input timing
//               pixel_in[23:0]                    - {Y, Cb, Cr}
//               hsync_out, vsync_out, de_out      - timing delayed 2 cycles
//               pixel_out[23:0]                   - RGB mask / crosshair
//               centroid_x, centroid_y            - last centroid
//               centroid_valid                    - centroid from non-empty frame
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr_centroid
  import ycbcr_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int CB_MIN = CB_MIN_DEF,
  parameter int CB_MAX = CB_MAX_DEF,
  parameter int CR_MIN = CR_MIN_DEF,
  parameter int CR_MAX = CR_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           de_in,
  input  logic [23:0]    pixel_in,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           de_out,
  output logic [23:0]    pixel_out,
  output logic [X_W-1:0] centroid_x,
  output logic [Y_W-1:0] centroid_y,
  output logic           centroid_valid
);

  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

  // ---------------------------------------------------------------- mask
  logic [7:0] unused_luma;
  logic       fg;

  assign unused_luma = pixel_in[23:16];
  assign fg = in_window(pixel_in[15:8], 8'(CB_MIN), 8'(CB_MAX)) &&
              in_window(pixel_in[7:0],  8'(CR_MIN), 8'(CR_MAX));

  // ------------------------------------------------ stage 1 and counters
  logic           de_s1;
  logic           fg_s1;
  logic [X_W-1:0] x_s1;
  logic [Y_W-1:0] y_s1;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           vsync_prev;
  logic           de_fall;
  logic           frame_end;
  logic           pix_hit;

  // de_s1 doubles as the previous-cycle de for edge detection
  assign de_fall   = de_s1 && !de_in;
  assign frame_end = vsync_in && !vsync_prev;
  assign pix_hit   = de_in && fg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_s1      <= 1'b0;
      fg_s1      <= 1'b0;
      x_s1       <= '0;
      y_s1       <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      vsync_prev <= 1'b0;
    end else begin
      de_s1      <= de_in;
      fg_s1      <= fg;
      x_s1       <= x_cnt;
      y_s1       <= y_cnt;
      vsync_prev <= vsync_in;

      if (de_fall) begin
        x_cnt <= '0;
      end else if (de_in && (x_cnt != X_MAX)) begin
        x_cnt <= x_cnt + X_W'(1);
      end

      if (frame_end) begin
        y_cnt <= '0;
      end else if (de_fall && (y_cnt != Y_MAX)) begin
        y_cnt <= y_cnt + Y_W'(1);
      end
    end
  end

  // --------------------------------------------------------- accumulators
  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic [CNT_W-1:0] cnt;

  // On frame end the old totals go to the dividers (which sample them on
  // start) and a coincident foreground pixel seeds the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (frame_end) begin
      sum_x <= pix_hit ? SUM_W'(x_cnt) : '0;
      sum_y <= pix_hit ? SUM_W'(y_cnt) : '0;
      cnt   <= pix_hit ? CNT_W'(1)     : '0;
    end else if (pix_hit) begin
      sum_x <= sum_x + SUM_W'(x_cnt);
      sum_y <= sum_y + SUM_W'(y_cnt);
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------- dividers
  logic           start_div;
  logic           busy_x;
  logic           busy_y;
  logic           done_x;
  logic           done_y;
  logic [X_W-1:0] quo_x;
  logic [Y_W-1:0] quo_y;

  seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(X_W)) u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (sum_x),
    .divisor  (cnt),
    .busy     (busy_x),
    .done     (done_x),
    .quotient (quo_x)
  );

  seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(Y_W)) u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (sum_y),
    .divisor  (cnt),
    .busy     (busy_y),
    .done     (done_y),
    .quotient (quo_y)
  );

  // ------------------------------------------------------------------- FSM
  div_state_t state;
  div_state_t state_nxt;
  logic       load_res;
  logic       clr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_div = 1'b0;
    load_res  = 1'b0;
    clr_valid = 1'b0;

    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_DIV: begin
        if (done_x && done_y) begin
          state_nxt = ST_DONE;
        end else if (!busy_x || !busy_y) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        load_res  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A new frame end always wins: restart on fresh operands or, for an
    // empty frame, abandon any division and invalidate the centroid.
    if (frame_end) begin
      load_res = 1'b0;
      if (cnt != '0) begin
        start_div = 1'b1;
        state_nxt = ST_DIV;
      end else begin
        clr_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      centroid_x     <= '0;
      centroid_y     <= '0;
      centroid_valid <= 1'b0;
    end else if (load_res) begin
      centroid_x     <= quo_x;
      centroid_y     <= quo_y;
      centroid_valid <= 1'b1;
    end else if (clr_valid) begin
      centroid_valid <= 1'b0;
    end
  end

  // --------------------------------------------------- stage 2: overlay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_out <= '0;
    end else if (!de_s1) begin
      pixel_out <= '0;
    end else if (centroid_valid && ((x_s1 == centroid_x) || (y_s1 == centroid_y))) begin
      pixel_out <= 24'hFF0000;
    end else begin
      pixel_out <= fg_s1 ? 24'hFFFFFF : 24'h000000;
    end
  end

  // -------------------------------------------------------- sync delay
  delayline #(.N(3), .DELAY(2)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({hsync_in, vsync_in, de_in}),
    .dout  ({hsync_out, vsync_out, de_out})
  );

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_centroid.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr_centroid
// Description : Directed self-checking bench for ycbcr_centroid on a 16x8
//               frame.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ycbcr_centroid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        de_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic [23:0] pixel_out;
  logic [10:0] centroid_x;
  logic [9:0]  centroid_y;
  logic        centroid_valid;

  ycbcr_centroid #(.IMG_W(16), .IMG_H(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .de_in          (de_in),
    .pixel_in       (pixel_in),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .de_out         (de_out),
    .pixel_out      (pixel_out),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .centroid_valid (centroid_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] img [8][16];

  // two-deep expectation pipeline for pixel_out and {hsync,vsync,de}
  logic [23:0] e1_pix = '0, e2_pix = '0;
  logic [2:0]  e1_sync = '0, e2_sync = '0;

  // expected centroid outputs
  logic exp_valid = 1'b0;
  int   exp_cx = 0;
  int   exp_cy = 0;

  localparam logic [23:0] BG = {8'h80, 8'd128, 8'd128};
  localparam logic [23:0] FG = {8'h60, 8'd100, 8'd150};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_fg(input logic [23:0] p);
    return (p[15:8] >= 8'd77) && (p[15:8] <= 8'd127) &&
           (p[7:0]  >= 8'd133) && (p[7:0]  <= 8'd173);
  endfunction

  // One clock: check the outputs due now, then drive the next input.
  task automatic step(input logic h, input logic v, input logic d,
                      input logic [23:0] p, input int xx, input int yy);
    @(posedge clk);
    #1;
    chk("pix",  32'(pixel_out), 32'(e2_pix));
    chk("sync", 32'({hsync_out, vsync_out, de_out}), 32'(e2_sync));
    e2_pix  = e1_pix;
    e2_sync = e1_sync;
    hsync_in = h;
    vsync_in = v;
    de_in    = d;
    pixel_in = p;
    if (!d)
      e1_pix = 24'h0;
    else if (exp_valid && (xx == exp_cx || yy == exp_cy))
      e1_pix = 24'hFF0000;
    else
      e1_pix = is_fg(p) ? 24'hFFFFFF : 24'h000000;
    e1_sync = {h, v, d};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
  endtask

  task automatic fill_bg();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = BG;
  endtask

  task automatic put(input int c, input int r, input logic [7:0] cb, input logic [7:0] cr);
    img[r][c] = {8'h40, cb, cr};
  endtask

  task automatic run_frame();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) step(1'b0, 1'b0, 1'b1, img[r][c], c, r);
      for (int b = 0; b < 4; b++) step(b < 2, 1'b0, 1'b0, 24'h0, 0, 0);
    end
  endtask

  // vsync pulse, then the centroid must hold its old value through edge 33
  // and show the new one after edge 34.
  task automatic frame_end_check(input logic nonempty, input int nx, input int ny);
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    if (!nonempty) begin
      exp_valid = 1'b0;
      chk("empty_drop", 32'(centroid_valid), 32'(0));
    end
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    idle(30);
    idle(1);
    chk("pre_valid", 32'(centroid_valid), 32'(exp_valid));
    chk("pre_x", 32'(centroid_x), 32'(exp_cx));
    chk("pre_y", 32'(centroid_y), 32'(exp_cy));
    idle(1);
    if (nonempty) begin
      exp_valid = 1'b1;
      exp_cx = nx;
      exp_cy = ny;
    end
    chk("valid", 32'(centroid_valid), 32'(exp_valid));
    chk("cx", 32'(centroid_x), 32'(exp_cx));
    chk("cy", 32'(centroid_y), 32'(exp_cy));
    idle(6);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    idle(3);
    chk("rst_pix",   32'(pixel_out), 32'(0));
    chk("rst_sync",  32'({hsync_out, vsync_out, de_out}), 32'(0));
    chk("rst_cx",    32'(centroid_x), 32'(0));
    chk("rst_cy",    32'(centroid_y), 32'(0));
    chk("rst_valid", 32'(centroid_valid), 32'(0));
    rst_n = 1'b1;
    idle(4);

    // single pixel at (5,3)
    fill_bg();
    put(5, 3, 8'd100, 8'd150);
    run_frame();
    frame_end_check(1'b1, 5, 3);

    // 2x2 block at (4..5, 2..3): sums 18/10, cnt 4 -> (4,2); overlay of (5,3)
    fill_bg();
    put(4, 2, 8'd100, 8'd150); put(5, 2, 8'd100, 8'd150);
    put(4, 3, 8'd100, 8'd150); put(5, 3, 8'd100, 8'd150);
    run_frame();
    frame_end_check(1'b1, 4, 2);

    // threshold edges on row 6: x=8..11 inside, x=12..15 just outside
    // sum_x 38 / 4 -> 9, y 6
    fill_bg();
    put(8,  6, 8'd77,  8'd150);
    put(9,  6, 8'd127, 8'd150);
    put(10, 6, 8'd100, 8'd133);
    put(11, 6, 8'd100, 8'd173);
    put(12, 6, 8'd76,  8'd150);
    put(13, 6, 8'd128, 8'd150);
    put(14, 6, 8'd100, 8'd132);
    put(15, 6, 8'd100, 8'd174);
    run_frame();
    frame_end_check(1'b1, 9, 6);

    // empty frames: valid drops, (9,6) retained; second frame is all black
    fill_bg();
    run_frame();
    frame_end_check(1'b0, 0, 0);
    run_frame();
    frame_end_check(1'b0, 0, 0);

    // abort: frame with (5,3), then a short burst and a second vsync
    // 10 cycles after the first; burst fg at x=1,2 on row 0 -> (1,0)
    fill_bg();
    put(5, 3, 8'd100, 8'd150);
    run_frame();
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, BG, 0, 0);
    step(1'b0, 1'b0, 1'b1, FG, 1, 0);
    step(1'b0, 1'b0, 1'b1, FG, 2, 0);
    idle(3);
    frame_end_check(1'b1, 1, 0);

    // reset in the middle of a division
    fill_bg();
    put(4, 2, 8'd100, 8'd150); put(5, 3, 8'd100, 8'd150);
    run_frame();
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    idle(13);
    rst_n = 1'b0;
    idle(2);
    exp_valid = 1'b0;
    exp_cx = 0;
    exp_cy = 0;
    chk("mrst_cx",    32'(centroid_x), 32'(0));
    chk("mrst_cy",    32'(centroid_y), 32'(0));
    chk("mrst_valid", 32'(centroid_valid), 32'(0));
    chk("mrst_pix",   32'(pixel_out), 32'(0));
    rst_n = 1'b1;
    idle(40);
    chk("nodone_valid", 32'(centroid_valid), 32'(0));
    chk("nodone_cx",    32'(centroid_x), 32'(0));
    chk("nodone_cy",    32'(centroid_y), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
